// File: rtl/interrupt_pkg.sv
`default_nettype none
// ============================================================================
// interrupt_pkg
// Shared FSM state encoding and default instruction encodings used by the
// interrupt injector and the decode stage.
// Revision: 1.0
// ============================================================================
package interrupt_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_IMM = 3'd1,
        BUBBLE   = 3'd2,
        INT1     = 3'd3,
        INT2     = 3'd4
    } irq_state_t;

    localparam logic [2:0]  c_IMM_FUNC    = 3'b100;
    localparam logic [15:0] c_NOP_INSTR   = 16'h07F8;
    localparam logic [15:0] c_INT_WORD1   = 16'hF480;
    localparam logic [15:0] c_INT_VEC_BASE = 16'h0000;

    // Index width for a request vector of n lines, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : interrupt_pkg
`default_nettype wire

// File: rtl/irq_priority_arbiter.sv
`default_nettype none
// ============================================================================
// irq_priority_arbiter
// Combinational fixed-priority pick: the lowest set index wins.
// Revision: 1.0
// ============================================================================
module irq_priority_arbiter
    import interrupt_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = idx_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx
);

    // Scan from the top down so the last assignment is the lowest index.
    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule : irq_priority_arbiter
`default_nettype wire

// File: rtl/interrupt_injector.sv
`default_nettype none
// ============================================================================
// interrupt_injector
// Captures interrupt edges, arbitrates by fixed priority and overrides fetch
// with bubbles followed by a two-word interrupt instruction.
// Revision: 1.0
// ============================================================================
module interrupt_injector
    import interrupt_pkg::*;
#(
    parameter int                 INSTR_W      = 16,
    parameter int                 NUM_IRQ      = 4,
    parameter int                 STALL_CYCLES = 1,
    parameter logic [2:0]         IMM_FUNC     = c_IMM_FUNC,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = c_NOP_INSTR,
    parameter logic [INSTR_W-1:0] INT_WORD1    = c_INT_WORD1,
    parameter logic [INSTR_W-1:0] INT_VEC_BASE = c_INT_VEC_BASE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] i_irq_req,
    input  logic [NUM_IRQ-1:0] i_irq_mask,
    input  logic [2:0]         i_func_bits,
    output logic               o_inject_valid,
    output logic [INSTR_W-1:0] o_inject_instr,
    output logic               o_pc_hold,
    output logic [NUM_IRQ-1:0] o_irq_ack,
    output logic               o_busy
);

    localparam int                 c_IDX_W    = idx_width(NUM_IRQ);
    localparam logic [2:0]         c_CNT_INIT = 3'(STALL_CYCLES - 1);
    localparam logic [NUM_IRQ-1:0] c_ONE      = NUM_IRQ'(1);

    logic [NUM_IRQ-1:0] r_req_d;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_elig;
    logic               w_any;
    logic [c_IDX_W-1:0] w_idx;

    irq_state_t         r_state;
    logic [2:0]         r_cnt;
    logic [c_IDX_W-1:0] r_cur_id;

    assign w_edge = i_irq_req & ~r_req_d;
    assign w_elig = r_pend & ~i_irq_mask;

    // A fresh edge in the ack cycle must survive the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_d <= '0;
            r_pend  <= '0;
        end else begin
            r_req_d <= i_irq_req;
            r_pend  <= (r_pend & ~o_irq_ack) | w_edge;
        end
    end

    irq_priority_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (c_IDX_W)
    ) u_arbiter (
        .i_req (w_elig),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_cur_id       <= '0;
            o_inject_valid <= 1'b0;
            o_inject_instr <= NOP_INSTR;
            o_pc_hold      <= 1'b0;
            o_irq_ack      <= '0;
            o_busy         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    o_irq_ack <= '0;
                    if (w_any) begin
                        r_cur_id <= w_idx;
                        o_busy   <= 1'b1;
                        // Let the immediate word of a two-word instruction through first.
                        if (i_func_bits == IMM_FUNC) begin
                            r_state <= WAIT_IMM;
                        end else begin
                            r_state        <= BUBBLE;
                            r_cnt          <= c_CNT_INIT;
                            o_inject_valid <= 1'b1;
                            o_inject_instr <= NOP_INSTR;
                            o_pc_hold      <= 1'b1;
                        end
                    end
                end
                WAIT_IMM: begin
                    r_state        <= BUBBLE;
                    r_cnt          <= c_CNT_INIT;
                    o_inject_valid <= 1'b1;
                    o_inject_instr <= NOP_INSTR;
                    o_pc_hold      <= 1'b1;
                end
                BUBBLE: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_state        <= INT1;
                        o_inject_instr <= INT_WORD1;
                    end
                end
                INT1: begin
                    r_state        <= INT2;
                    o_inject_instr <= INT_VEC_BASE | INSTR_W'(r_cur_id);
                    o_irq_ack      <= c_ONE << r_cur_id;
                end
                INT2: begin
                    r_state        <= IDLE;
                    o_inject_valid <= 1'b0;
                    o_inject_instr <= NOP_INSTR;
                    o_pc_hold      <= 1'b0;
                    o_irq_ack      <= '0;
                    o_busy         <= 1'b0;
                end
                default: begin
                    r_state        <= IDLE;
                    o_inject_valid <= 1'b0;
                    o_inject_instr <= NOP_INSTR;
                    o_pc_hold      <= 1'b0;
                    o_irq_ack      <= '0;
                    o_busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule : interrupt_injector
`default_nettype wire
